// File: rtl/fifo_rd_stream.sv
// Read-domain drain stage: pops an async FIFO with one-cycle read latency and
// presents the words as a valid/ready stream through a 2-entry buffer.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [1:0]            level,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    logic [1:0]            level_q, level_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  fire;
    logic                  capture;
    logic [2:0]            occ;

    always_comb begin
        fire    = (level_q != 2'd0) && m_ready;
        // Slots committed after this edge: buffered plus in-flight minus leaving.
        occ     = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, fire};
        fifo_rd_en = !rd_rst && !flush && !fifo_rd_empty && (occ < 3'd2);
        // An in-flight word landing during a flush is dropped.
        capture = inflight_q && !flush;

        level_d = level_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;

        if (flush) begin
            level_d = 2'd0;
        end else begin
            case ({capture, fire})
                2'b11: begin
                    if (level_q == 2'd2) begin
                        ent0_d = ent1_q;
                        ent1_d = fifo_rd_data;
                    end else begin
                        ent0_d = fifo_rd_data;
                    end
                end
                2'b10: begin
                    if (level_q == 2'd0) begin
                        ent0_d  = fifo_rd_data;
                        level_d = 2'd1;
                    end else begin
                        ent1_d  = fifo_rd_data;
                        level_d = 2'd2;
                    end
                end
                2'b01: begin
                    // Only shift when entry 1 is live so m_data holds when draining to empty.
                    if (level_q == 2'd2) begin
                        ent0_d = ent1_q;
                    end
                    level_d = level_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            level_q    <= 2'd0;
            inflight_q <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            level_q    <= level_d;
            inflight_q <= fifo_rd_en;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            cnt_q      <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, fire};
        end
    end

    assign m_valid  = (level_q != 2'd0);
    assign m_data   = ent0_q;
    assign level    = level_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO with registered read, ordered
// scoreboard fed at push time and a negedge monitor checking every transfer.
module tb_fifo_rd_stream;

    logic        rd_clk;
    logic        rd_rst;
    logic        fifo_rd_en;
    logic        fifo_rd_empty;
    logic [31:0] fifo_rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        flush;
    logic [1:0]  level;
    logic [3:0]  beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [31:0] exp_q [$];

    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    fifo_rd_stream #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (4)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .flush        (flush),
        .level        (level),
        .beat_cnt     (beat_cnt)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    initial begin
        fifo_rd_data = '0;
    end

    assign fifo_rd_empty = (rd_ptr == wr_ptr);

    // FIFO model with one-cycle registered read data.
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    // Words buffered or in flight (popped but not yet delivered) are lost.
    task automatic drop_lost();
        int n;
        n = exp_q.size() - (wr_ptr - rd_ptr);
        repeat (n) void'(exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge rd_clk);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: inputs change just after posedge, so negedge values hold through the next edge.
    always @(negedge rd_clk) begin
        logic [31:0] e;
        if (rd_rst) begin
            check("en_in_reset", fifo_rd_en, 1'b0);
            prev_hold = 1'b0;
        end else begin
            if (fifo_rd_en && fifo_rd_empty) check("en_while_empty", 1'b1, 1'b0);
            if (prev_hold) check("data_stable", m_data, prev_data);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_data, 32'hdead_beef);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", m_data, e);
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rd_rst  = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge rd_clk);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_level", level, 0);
        check("rst_beat", beat_cnt, 0);
        step();
        rd_rst = 1'b0;

        // Latency and order
        m_ready = 1'b1;
        step();
        push(32'h11); push(32'h22); push(32'h33);
        @(negedge rd_clk);
        check("lat_en", fifo_rd_en, 1);
        check("lat_valid_n0", m_valid, 0);
        @(negedge rd_clk);
        check("lat_valid_n1", m_valid, 0);
        @(negedge rd_clk);
        check("lat_valid_n2", m_valid, 1);
        check("lat_d0", m_data, 32'h11);
        @(negedge rd_clk);
        check("lat_d1", m_data, 32'h22);
        @(negedge rd_clk);
        check("lat_d2", m_data, 32'h33);
        @(negedge rd_clk);
        check("lat_beat", beat_cnt, 3);
        check("lat_empty", m_valid, 0);
        check("lat_hold", m_data, 32'h33);

        // Backpressure
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h100 + i);
        repeat (3) @(negedge rd_clk);
        check("bp_first", m_valid, 1);
        repeat (4) @(negedge rd_clk);
        check("bp_level", level, 2);
        check("bp_en", fifo_rd_en, 0);
        check("bp_data", m_data, 32'h100);
        step();
        m_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_beat", beat_cnt, 4'hb);

        // Empty handling between bursts
        step();
        for (int i = 0; i < 3; i++) push(32'h150 + i);
        wait_drain("burst1_drain");
        for (int i = 0; i < 10; i++) begin
            @(negedge rd_clk);
            check("gap_valid", m_valid, 0);
            check("gap_en", fifo_rd_en, 0);
        end
        step();
        for (int i = 0; i < 3; i++) push(32'h160 + i);
        wait_drain("burst2_drain");

        // Flush with a word in flight
        step();
        m_ready = 1'b0;
        push(32'h99);
        repeat (3) @(negedge rd_clk);
        check("fl_level1", level, 1);
        check("fl_head", m_data, 32'h99);
        step();
        push(32'haa);
        @(negedge rd_clk);
        check("fl_pop", fifo_rd_en, 1);
        step();
        flush = 1'b1;
        drop_lost();
        @(negedge rd_clk);
        check("fl_no_pop", fifo_rd_en, 0);
        step();
        flush   = 1'b0;
        m_ready = 1'b1;
        push(32'hbb);
        @(negedge rd_clk);
        check("fl_level0", level, 0);
        check("fl_valid0", m_valid, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge rd_clk);
            check("fl_no_aa", m_data == 32'haa, 0);
        end
        wait_drain("fl_drain");

        // Reset mid-stream with a full buffer
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h200 + i);
        repeat (4) @(negedge rd_clk);
        check("rs_level2", level, 2);
        @(posedge rd_clk);
        #3;
        rd_rst = 1'b1;
        drop_lost();
        #1;
        check("rs_valid", m_valid, 0);
        check("rs_data", m_data, 0);
        check("rs_level", level, 0);
        check("rs_beat", beat_cnt, 0);
        repeat (3) @(negedge rd_clk);
        step();
        rd_rst = 1'b0;
        @(negedge rd_clk);
        check("rs_first_pop", fifo_rd_en, 1);
        step();
        m_ready = 1'b1;
        wait_drain("rs_drain");

        // Counter wrap at 4 bits
        step();
        rd_rst = 1'b1;
        step();
        rd_rst = 1'b0;
        for (int i = 0; i < 17; i++) push(32'h300 + i);
        repeat (2) @(negedge rd_clk);
        for (int i = 0; i < 18; i++) begin
            logic [3:0] want;
            want = 4'(i);
            @(negedge rd_clk);
            check("wrap_beat", beat_cnt, want);
        end
        wait_drain("wrap_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-domain drain stage that sits directly downstream of the asynchronous FIFO's read port. It issues pops against the FIFO's `rd_en`/`rd_empty` interface and absorbs the FIFO's one-cycle registered read latency. It presents the words as a valid/ready stream with a 2-entry output buffer, sustaining one word per cycle under continuous `m_ready`. A flush clears buffered and in-flight data, and a free-running beat counter supports bring-up.

## Interface
- `DATA_WIDTH`, default 32: width of FIFO words and stream data.
- `CNT_WIDTH`, default 32: width of `beat_cnt`.

Ports:
- `rd_clk`, input, 1: read-domain clock; the only clock.
- `rd_rst`, input, 1: reset, asynchronous, active-high.
- `fifo_rd_en`, output, 1: pop request to the FIFO.
- `fifo_rd_empty`, input, 1: FIFO empty flag.
- `fifo_rd_data`, input, DATA_WIDTH: FIFO read data, valid the cycle after an accepted pop.
- `m_valid`, output, 1: stream word available.
- `m_ready`, input, 1: downstream accepts the word.
- `m_data`, output, DATA_WIDTH: stream data; the buffer head.
- `flush`, input, 1: synchronous clear of buffer and in-flight word.
- `level`, output, 2: buffer occupancy, 0..2.
- `beat_cnt`, output, CNT_WIDTH: count of stream transfers (`m_valid && m_ready`); wraps.

## Operation
- **Pop.** A pop is issued in cycle N when `fifo_rd_en=1` in N. `fifo_rd_en` is never 1 while `fifo_rd_empty=1`.
- **Capture.** The word popped in cycle N is captured from `fifo_rd_data` at the rising edge ending cycle N+1. An `inflight` flag marks that pending capture.
- **Pop condition.**
  - fire = `m_valid && m_ready`.
  - `fifo_rd_en` = `!rd_rst && !flush && !fifo_rd_empty && (level + inflight - fire) < 2`.
  - This makes `m_ready` → `fifo_rd_en` a combinational path; that path is intentional.
  - The buffer never overflows: every popped word has a guaranteed slot.
- **Buffer.**
  - 2-entry in-order register buffer.
  - `m_data` is entry 0, driven from a register.
  - `m_valid` = (`level != 0`).
  - On fire, entry 1 shifts to entry 0.
- **Simultaneous fire and capture.**
  - At level 1, the incoming word takes entry 0.
  - At level 2, entry 1 moves to entry 0 and the incoming word takes entry 1; level stays 2.
- **`m_data` when empty.** When `level=0`, `m_data` holds its last value. It is not cleared.
- **Flush.**
  - A cycle with `flush=1` forces `level` to 0 at the next edge, and no pop is issued.
  - A word already in flight (popped the cycle before the flush) is discarded on arrival and does not enter the buffer.
  - `beat_cnt` is unaffected by flush.
  - A fire in the flush cycle still counts.
- **Beat counter.** `beat_cnt` increments by 1 on every fire and wraps from 2^CNT_WIDTH-1 to 0.
- **Reset.**
  - All state clears immediately on `rd_rst` assertion: `level=0`, `inflight=0`, `m_valid=0`, `m_data=0`, `beat_cnt=0`.
  - `fifo_rd_en=0` for as long as `rd_rst` is high.
  - A word in flight at reset assertion is lost; it is not replayed.

## Timing
- **Fill latency.** Buffer empty and `fifo_rd_empty` falls in cycle N: `fifo_rd_en=1` in N, capture at the end of N+1, `m_valid=1` in N+2. Latency is 2 cycles.
- **Throughput.** With `m_ready=1` continuously and the FIFO non-empty, one pop and one fire occur every cycle. Steady state is `level=1`, `inflight=1`.
- **Backpressure.** When `m_ready` drops, at most one further pop completes and the buffer settles at `level=2` with `fifo_rd_en=0`. When `m_ready` returns, the next pop is issued in the same cycle as the fire.
- **Observation point.** `level`, `m_valid` and `beat_cnt` are registered and change only at `rd_clk` edges.
- **Stability rules.**
  - `m_data` is stable while `m_valid && !m_ready`.
  - `m_valid` never drops without a fire, except on flush or reset.
- **Reset release.** The first pop may occur in the first cycle after `rd_rst` deasserts.

## Test plan
- **Reset values:** assert `rd_rst` mid-stream with `level=2` → `m_valid=0`, `m_data=0`, `level=0`, `beat_cnt=0` immediately, and `fifo_rd_en=0` throughout reset.
- **Latency and order:** FIFO preloaded with 0x11, 0x22, 0x33 and `m_ready=1` → first `m_valid` 2 cycles after `fifo_rd_empty` falls; data out 0x11, 0x22, 0x33 on consecutive cycles; `beat_cnt=3`.
- **Backpressure:** 8 words, `m_ready=0` for 5 cycles after the first word appears → `level` saturates at 2, `fifo_rd_en=0`, `m_data` held at word 0. After release, all 8 words arrive in order with no duplicates or drops.
- **Empty handling:** FIFO empty for 10 cycles between bursts → `fifo_rd_en` never high while `fifo_rd_empty=1`; `m_valid=0` once drained.
- **Flush with in-flight word:** assert `flush` the cycle after a pop of 0xAA, with `level=1` holding 0x99 → `level=0` next cycle; 0xAA never appears on `m_data`; the following word 0xBB is delivered normally.
- **Counter wrap:** `CNT_WIDTH=4`, 17 transfers → `beat_cnt` reads 0xF after 15 transfers, then 0x0 and 0x1.
